// File: rtl/mips_cpu_mem_access.sv
// Load/store unit: one word-addressed Avalon-style access per request, big-endian lane
// steering on stores, and extend/merge of the loaded word for writeback.
module mips_cpu_mem_access #(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] rt,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_byteenable,
    output logic [31:0] mem_writedata,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_readdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] result
);

    localparam logic [3:0] OpLb  = 4'd0;
    localparam logic [3:0] OpLbu = 4'd1;
    localparam logic [3:0] OpLh  = 4'd2;
    localparam logic [3:0] OpLhu = 4'd3;
    localparam logic [3:0] OpLw  = 4'd4;
    localparam logic [3:0] OpLwl = 4'd5;
    localparam logic [3:0] OpLwr = 4'd6;
    localparam logic [3:0] OpSb  = 4'd8;
    localparam logic [3:0] OpSh  = 4'd9;
    localparam logic [3:0] OpSw  = 4'd10;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StFinish
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] rt_q, rt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_pend_q, err_pend_d;
    logic [31:0] tmo_cnt_q, tmo_cnt_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic [3:0]  mem_byteenable_q, mem_byteenable_d;
    logic [31:0] mem_writedata_q, mem_writedata_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] result_q, result_d;

    // Request decode: legality, alignment and store lane steering from the raw inputs.
    logic        op_legal;
    logic        op_aligned;
    logic [3:0]  st_be;
    logic [31:0] st_wd;

    always_comb begin
        op_legal   = 1'b0;
        op_aligned = 1'b1;
        st_be      = 4'b0000;
        st_wd      = 32'h0;
        case (op)
            OpLb, OpLbu, OpLwl, OpLwr: begin
                op_legal = 1'b1;
            end
            OpLh, OpLhu: begin
                op_legal   = 1'b1;
                op_aligned = ~addr[0];
            end
            OpLw: begin
                op_legal   = 1'b1;
                op_aligned = (addr[1:0] == 2'b00);
            end
            OpSb: begin
                op_legal = 1'b1;
                st_be    = 4'b1000 >> addr[1:0];
                st_wd    = {4{rt[7:0]}};
            end
            OpSh: begin
                op_legal   = 1'b1;
                op_aligned = ~addr[0];
                st_be      = 4'b1100 >> addr[1:0];
                st_wd      = {2{rt[15:0]}};
            end
            OpSw: begin
                op_legal   = 1'b1;
                op_aligned = (addr[1:0] == 2'b00);
                st_be      = 4'b1111;
                st_wd      = rt;
            end
            default: begin
                op_legal = 1'b0;
            end
        endcase
    end

    // Load extraction from the captured word; byte 0 is the most significant lane.
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [4:0]  lwl_sh;
    logic [4:0]  lwr_sh;
    logic [31:0] ld_result;

    always_comb begin
        lwl_sh  = {off_q, 3'b000};
        lwr_sh  = {~off_q, 3'b000};
        ld_half = off_q[1] ? rdata_q[15:0] : rdata_q[31:16];
        case (off_q)
            2'd0:    ld_byte = rdata_q[31:24];
            2'd1:    ld_byte = rdata_q[23:16];
            2'd2:    ld_byte = rdata_q[15:8];
            default: ld_byte = rdata_q[7:0];
        endcase
        case (op_q)
            OpLb:    ld_result = {{24{ld_byte[7]}}, ld_byte};
            OpLbu:   ld_result = {24'h0, ld_byte};
            OpLh:    ld_result = {{16{ld_half[15]}}, ld_half};
            OpLhu:   ld_result = {16'h0, ld_half};
            OpLw:    ld_result = rdata_q;
            OpLwl:   ld_result = (rdata_q << lwl_sh) | (rt_q & ~(32'hFFFF_FFFF << lwl_sh));
            OpLwr:   ld_result = (rdata_q >> lwr_sh) | (rt_q & ~(32'hFFFF_FFFF >> lwr_sh));
            default: ld_result = 32'h0;
        endcase
    end

    always_comb begin
        state_d          = state_q;
        op_d             = op_q;
        off_d            = off_q;
        rt_d             = rt_q;
        rdata_d          = rdata_q;
        err_pend_d       = err_pend_q;
        tmo_cnt_d        = tmo_cnt_q;
        mem_address_d    = mem_address_q;
        mem_read_d       = mem_read_q;
        mem_write_d      = mem_write_q;
        mem_byteenable_d = mem_byteenable_q;
        mem_writedata_d  = mem_writedata_q;
        done_d           = 1'b0;
        err_d            = err_q;
        result_d         = result_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    if (op_legal && op_aligned) begin
                        op_d             = op;
                        off_d            = addr[1:0];
                        rt_d             = rt;
                        err_pend_d       = 1'b0;
                        tmo_cnt_d        = 32'h0;
                        mem_address_d    = {addr[31:2], 2'b00};
                        mem_read_d       = ~op[3];
                        mem_write_d      = op[3];
                        mem_byteenable_d = op[3] ? st_be : 4'b1111;
                        mem_writedata_d  = op[3] ? st_wd : 32'h0;
                        state_d          = StAccess;
                    end else begin
                        // Rejected requests never touch the bus.
                        err_pend_d = 1'b1;
                        state_d    = StFinish;
                    end
                end
            end
            StAccess: begin
                if (!mem_waitrequest) begin
                    if (mem_read_q) begin
                        rdata_d = mem_readdata;
                    end
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = StFinish;
                end else if (TIMEOUT_CYCLES != 0) begin
                    if (tmo_cnt_q == TIMEOUT_CYCLES - 32'd1) begin
                        mem_read_d  = 1'b0;
                        mem_write_d = 1'b0;
                        err_pend_d  = 1'b1;
                        state_d     = StFinish;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 32'd1;
                    end
                end
            end
            StFinish: begin
                done_d   = 1'b1;
                err_d    = err_pend_q;
                result_d = (err_pend_q || op_q[3]) ? 32'h0 : ld_result;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= StIdle;
            op_q             <= 4'h0;
            off_q            <= 2'b00;
            rt_q             <= 32'h0;
            rdata_q          <= 32'h0;
            err_pend_q       <= 1'b0;
            tmo_cnt_q        <= 32'h0;
            mem_address_q    <= 32'h0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_byteenable_q <= 4'b0000;
            mem_writedata_q  <= 32'h0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            err_q            <= 1'b0;
            result_q         <= 32'h0;
        end else begin
            state_q          <= state_d;
            op_q             <= op_d;
            off_q            <= off_d;
            rt_q             <= rt_d;
            rdata_q          <= rdata_d;
            err_pend_q       <= err_pend_d;
            tmo_cnt_q        <= tmo_cnt_d;
            mem_address_q    <= mem_address_d;
            mem_read_q       <= mem_read_d;
            mem_write_q      <= mem_write_d;
            mem_byteenable_q <= mem_byteenable_d;
            mem_writedata_q  <= mem_writedata_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            err_q            <= err_d;
            result_q         <= result_d;
        end
    end

    assign mem_address    = mem_address_q;
    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign mem_byteenable = mem_byteenable_q;
    assign mem_writedata  = mem_writedata_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign result         = result_q;

endmodule

// File: doc/mips_cpu_mem_access.md
Name: mips_cpu_mem_access

Overview:
Load/store unit directly downstream of the ALU. It takes the ALU result as the effective byte address, plus the rt register value. It runs one Avalon-style word-addressed bus transaction with waitrequest stall and big-endian byte-lane steering, and returns the extended or merged load result to writeback. It is multi-cycle, handles one access at a time, and the core stalls on busy.

Parameters:
TIMEOUT_CYCLES, 0, max cycles read/write may be held under waitrequest before abort; 0 disables the timeout.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle request; sampled only in IDLE
op  input  4  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWL, 6 LWR, 8 SB, 9 SH, 10 SW; other codes are illegal
addr  input  32  effective byte address (ALU result)
rt  input  32  store data, or old rt for LWL/LWR merge
mem_address  output  32  word address {addr[31:2],2'b00}
mem_read  output  1  read request
mem_write  output  1  write request
mem_byteenable  output  4  bit3 = data[31:24]
mem_writedata  output  32  lane-steered store data
mem_waitrequest  input  1  slave stall
mem_readdata  input  32  valid when mem_read=1 and mem_waitrequest=0
busy  output  1  high from the cycle after accepted start until done
done  output  1  one-cycle completion pulse
err  output  1  valid with done: misaligned, illegal op, or timeout
result  output  32  load result; valid with done and held until next done; 0 for stores and errors

Behaviour:
- Reset (asynchronous, active-low): state=IDLE. mem_read, mem_write, busy, done, err = 0. result, mem_address, mem_writedata = 0. mem_byteenable = 0. Timeout counter = 0.
- States and transitions:
  - IDLE: on start with a legal, aligned op, latch op, addr, rt; go to ACCESS.
  - IDLE: on start with a misaligned or illegal op, go to FINISH with err=1; no bus activity.
  - ACCESS: drive mem_read or mem_write from the first ACCESS cycle. Hold address, byteenable and writedata stable while mem_waitrequest=1.
  - ACCESS: on the first cycle with mem_waitrequest=0, the transfer is accepted. Capture mem_readdata (loads), deassert the request on the next edge, and go to FINISH.
  - FINISH: done=1 for exactly one cycle; return to IDLE.
- Latency with no stall: start at edge N, request visible after edge N, done high after edge N+2. Each waitrequest cycle adds one.
- start while busy is ignored, not queued. start in the FINISH cycle is also ignored.
- Alignment: LH, LHU and SH need addr[0]=0. LW and SW need addr[1:0]=0. LB, LBU, SB, LWL and LWR accept any offset.
- Big-endian lanes, offset k=addr[1:0]; byte k sits at bits [31-8k -: 8].
- Load read strobes: mem_byteenable=4'b1111 for all loads.
- Store strobes and data:
  - SB: byteenable = 4'b1000>>k; writedata = {4{rt[7:0]}}.
  - SH: byteenable = 1100 for k=0, 0011 for k=2; writedata = {2{rt[15:0]}}.
  - SW: byteenable = 1111; writedata = rt.
- Load results, with word w = captured readdata:
  - LB / LBU: byte k, sign- or zero-extended.
  - LH / LHU: halfword k/2, sign- or zero-extended.
  - LW: w.
  - LWL: (w << 8k) | (rt & ((1<<8k)-1)).
  - LWR: (w >> 8(3-k)) | (rt & ~(32'hFFFFFFFF >> 8(3-k))).
- Timeout: when TIMEOUT_CYCLES>0, count ACCESS cycles with waitrequest=1. On reaching TIMEOUT_CYCLES, drop the request, go to FINISH with err=1 and result=0.
- Reset mid-ACCESS: requests drop immediately (asynchronous); no done pulse.
- err=0 and result=0 outside the done cycle is not required; both are only sampled with done.

Test Plan:
- LW addr=0x100, readdata=0x11223344, waitrequest 0 → mem_address=0x100, byteenable=1111, done 2 cycles after start, result=0x11223344, err=0.
- LB addr=0x103, readdata=0x112233F4 → result=0xFFFFFFF4; LBU gives 0x000000F4; LH addr=0x102 with readdata 0x1122_8001 → 0xFFFF8001.
- SB addr=0x201, rt=0xAABBCCDD, waitrequest high 3 cycles → mem_write held 4 cycles with byteenable=0100 and writedata=0xDDDDDDDD stable; done follows the accept cycle.
- LWL addr=0x301, rt=0xAABBCCDD, readdata=0x11223344 → 0x223344DD. LWR addr=0x301 → 0xAABB1122.
- SW addr=0x402 → no mem_write, done next-but-one cycle with err=1. Opcode 7 → err=1. With TIMEOUT_CYCLES=4 and waitrequest stuck high → request dropped after 4 cycles, err=1.
- Assert reset low mid-stall → mem_read=0 immediately, busy=0, no done. start while busy → ignored; only one transaction is seen on the bus.
